// File: rtl/gmii_tx_engine_if.sv
// gmii_tx_engine_if
//   Byte-stream handshake between an upstream frame source and the GMII
//   transmit engine.
//   c_srdy : source has a valid byte on c_data/c_code
//   c_drdy : sink accepts the byte this cycle (transfer = c_srdy & c_drdy)
//   c_data : frame byte
//   c_code : byte tag, 00 MOP, 01 SOP, 10 EOP, 11 BAD_EOP
//   master : the upstream source side
//   slave  : the transmit engine side
interface gmii_tx_engine_if;
  logic       c_srdy;
  logic       c_drdy;
  logic [7:0] c_data;
  logic [1:0] c_code;

  modport master (
    output c_srdy,
    output c_data,
    output c_code,
    input  c_drdy
  );

  modport slave (
    input  c_srdy,
    input  c_data,
    input  c_code,
    output c_drdy
  );
endinterface

// File: rtl/gmii_tx_engine.sv
// gmii_tx_engine
//   Turns a tagged byte stream into GMII transmit frames: preamble, SFD,
//   frame bytes, optional CRC-32 FCS and an enforced inter-frame gap.
//   A source that starves mid-frame truncates the frame (underrun) and the
//   rest of that frame is drained and discarded.
//
//   Parameters
//     IFG_LEN    minimum idle cycles after each frame (1..255)
//     PRE_LEN    number of 0x55 preamble bytes before the SFD (1..15)
//   Ports
//     clk        core clock, rising edge
//     reset      asynchronous, active-high reset
//     c          byte-stream handshake (slave side)
//     gmii_tx_en GMII transmit enable (registered)
//     gmii_txd   GMII transmit data (registered)
//     gmii_tx_er GMII transmit error (registered)
//     underrun   one-cycle pulse when a frame is truncated by starvation
//     frame_done one-cycle pulse on the first IFG cycle of every frame
//   Configuration
//     GMII_TX_FCS_EN  when defined, a 4-byte IEEE 802.3 CRC-32 is appended
//                     after EOP; when undefined no CRC logic exists and the
//                     frame bytes are expected to carry their own FCS.
module gmii_tx_engine #(
  parameter int unsigned IFG_LEN = 12,
  parameter int unsigned PRE_LEN = 7
) (
  input  logic             clk,
  input  logic             reset,
  gmii_tx_engine_if.slave  c,
  output logic             gmii_tx_en,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_er,
  output logic             underrun,
  output logic             frame_done
);

  localparam logic [1:0] CODE_MOP = 2'b00;
  localparam logic [1:0] CODE_SOP = 2'b01;
  localparam logic [1:0] CODE_EOP = 2'b10;
  localparam logic [1:0] CODE_BAD = 2'b11;

  localparam logic [7:0] PRE_LEN_C  = 8'(PRE_LEN);
  localparam logic [7:0] IFG_LAST_C = 8'(IFG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    FCS  = 3'd3,
    DROP = 3'd4,
    IFG  = 3'd5
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] txd_s;
  logic       tx_en_s;
  logic       tx_er_s;
  logic       underrun_s;
  logic       frame_done_s;
  logic       drdy_s;

`ifdef GMII_TX_FCS_EN
  logic [31:0] crc_r, crc_s;
  logic [31:0] crc_fin_s;

  // Reflected CRC-32 (poly 0x04C11DB7 bit-reversed) advanced by one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
    logic [31:0] crc_v;
    crc_v = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_v[0]) begin
        crc_v = (crc_v >> 1) ^ 32'hEDB88320;
      end else begin
        crc_v = crc_v >> 1;
      end
    end
    return crc_v;
  endfunction
`endif

  // Acceptance is forced low while reset is held, independent of state.
  assign c.c_drdy = drdy_s & ~reset;

  // Next-state, next-output and handshake decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    txd_s        = 8'h00;
    tx_en_s      = 1'b0;
    tx_er_s      = 1'b0;
    underrun_s   = 1'b0;
    frame_done_s = 1'b0;
    drdy_s       = 1'b0;
`ifdef GMII_TX_FCS_EN
    crc_s        = crc_r;
    crc_fin_s    = ~crc_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_s = 8'd0;
        if (c.c_srdy && (c.c_code == CODE_SOP)) begin
          // SOP stays on the bus; it is taken in the SFD cycle.
          state_s = PRE;
          cnt_s   = 8'd1;
          tx_en_s = 1'b1;
          txd_s   = 8'h55;
`ifdef GMII_TX_FCS_EN
          crc_s   = 32'hFFFFFFFF;
`endif
        end else begin
          drdy_s = 1'b1;
        end
      end
      PRE: begin
        tx_en_s = 1'b1;
        if (cnt_r < PRE_LEN_C) begin
          txd_s = 8'h55;
          cnt_s = cnt_r + 8'd1;
        end else begin
          // SFD goes out while DATA already accepts the SOP byte.
          txd_s   = 8'hD5;
          cnt_s   = 8'd0;
          state_s = DATA;
        end
      end
      DATA: begin
        drdy_s = 1'b1;
        if (c.c_srdy) begin
          tx_en_s = 1'b1;
          txd_s   = c.c_data;
`ifdef GMII_TX_FCS_EN
          crc_s   = crc32_byte(crc_r, c.c_data);
`endif
          if (c.c_code == CODE_EOP) begin
            cnt_s = 8'd0;
`ifdef GMII_TX_FCS_EN
            state_s = FCS;
`else
            state_s      = IFG;
            frame_done_s = 1'b1;
`endif
          end else if (c.c_code == CODE_BAD) begin
            tx_er_s      = 1'b1;
            cnt_s        = 8'd0;
            state_s      = IFG;
            frame_done_s = 1'b1;
          end else begin
            // MOP, and a stray SOP, are ordinary payload.
            state_s = DATA;
          end
        end else begin
          underrun_s = 1'b1;
          state_s    = DROP;
        end
      end
      FCS: begin
`ifdef GMII_TX_FCS_EN
        tx_en_s = 1'b1;
        txd_s   = crc_fin_s[{cnt_r[1:0], 3'b000} +: 8];
        if (cnt_r[1:0] == 2'd3) begin
          cnt_s        = 8'd0;
          state_s      = IFG;
          frame_done_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
`else
        cnt_s   = 8'd0;
        state_s = IFG;
`endif
      end
      DROP: begin
        drdy_s = 1'b1;
        if (c.c_srdy && ((c.c_code == CODE_EOP) || (c.c_code == CODE_BAD))) begin
          cnt_s        = 8'd0;
          state_s      = IFG;
          frame_done_s = 1'b1;
        end else begin
          state_s = DROP;
        end
      end
      IFG: begin
        // The cycle showing the last frame byte is IFG cycle 0, so exactly
        // IFG_LEN idle output cycles precede the next preamble.
        if (cnt_r == IFG_LAST_C) begin
          cnt_s   = 8'd0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        cnt_s   = 8'd0;
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered GMII/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      gmii_tx_er <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
`ifdef GMII_TX_FCS_EN
      crc_r      <= 32'h00000000;
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      gmii_tx_en <= tx_en_s;
      gmii_txd   <= txd_s;
      gmii_tx_er <= tx_er_s;
      underrun   <= underrun_s;
      frame_done <= frame_done_s;
`ifdef GMII_TX_FCS_EN
      crc_r      <= crc_s;
`endif
    end
  end

endmodule

// File: tb/tb_gmii_tx_engine.sv
// tb_gmii_tx_engine
//   Directed bench for gmii_tx_engine (IFG_LEN=12, PRE_LEN=7). A monitor
//   logs the GMII outputs every cycle; each step drives a frame and then
//   checks the logged window against hand-computed expectations.
module tb_gmii_tx_engine;

  localparam logic [1:0] MOP = 2'b00;
  localparam logic [1:0] SOP = 2'b01;
  localparam logic [1:0] EOP = 2'b10;
  localparam logic [1:0] BAD = 2'b11;
`ifdef GMII_TX_FCS_EN
  localparam int FCS_EXTRA = 4;
`else
  localparam int FCS_EXTRA = 0;
`endif

  logic       clk;
  logic       reset;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       gmii_tx_er;
  logic       underrun;
  logic       frame_done;

  gmii_tx_engine_if cif ();

  gmii_tx_engine #(.IFG_LEN(12), .PRE_LEN(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .c          (cif),
    .gmii_tx_en (gmii_tx_en),
    .gmii_txd   (gmii_txd),
    .gmii_tx_er (gmii_tx_er),
    .underrun   (underrun),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [7:0] txd;
    logic       er;
    logic       und;
    logic       done;
  } smp_t;

  smp_t       log_q[$];
  logic [7:0] seq_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  int n_en, n_done, n_und, n_er, first_en, last_en, gap, und_idx, er_idx;
  int tests = 0;
  int fails = 0;
  int mark;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    log_q.push_back({gmii_tx_en, gmii_txd, gmii_tx_er, underrun, frame_done});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Offer one byte from a negedge; returns on the negedge after the transfer.
  task automatic push(input logic [7:0] d, input logic [1:0] code);
    int n;
    n = 0;
    cif.c_srdy = 1'b1;
    cif.c_data = d;
    cif.c_code = code;
    #1;
    while (!cif.c_drdy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("push_timeout", 32'(n), 32'd0);
    end
    @(negedge clk);
    cif.c_srdy = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] end_code);
    for (int k = 0; k < pay_q.size(); k++) begin
      if (k == 0) push(pay_q[k], SOP);
      else if (k == pay_q.size() - 1) push(pay_q[k], end_code);
      else push(pay_q[k], MOP);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < pay_q.size(); k++) exp_q.push_back(pay_q[k]);
  endtask

  task automatic analyze(input int from);
    seq_q.delete();
    n_en = 0; n_done = 0; n_und = 0; n_er = 0;
    first_en = -1; last_en = -1; gap = -1; und_idx = -1; er_idx = -1;
    for (int i = from; i < log_q.size(); i++) begin
      if (log_q[i].en) begin
        seq_q.push_back(log_q[i].txd);
        n_en++;
        if (first_en < 0) first_en = i - from;
        else if (gap < 0 && (i - from) > last_en + 1) gap = (i - from) - last_en - 1;
        last_en = i - from;
      end
      if (log_q[i].er) begin n_er++; er_idx = i - from; end
      if (log_q[i].und) begin n_und++; und_idx = i - from; end
      if (log_q[i].done) n_done++;
    end
  endtask

  task automatic chk_seq(input string tag, input int base);
    for (int k = 0; k < exp_q.size(); k++) begin
      chk(tag, 32'(seq_q[base + k]), 32'(exp_q[k]));
    end
  endtask

  // Frame A: SOP 0x31, MOP 0x32..0x38, EOP 0x39.
  task automatic frame_a(input string tag);
    pay_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    build_exp();
    mark = log_q.size();
    send_frame(EOP);
    idle(30);
    analyze(mark);
    chk({tag, "_en_cycles"}, 32'(n_en), 32'(17 + FCS_EXTRA));
    chk({tag, "_contig"}, 32'(last_en - first_en + 1), 32'(17 + FCS_EXTRA));
    chk_seq({tag, "_bytes"}, 0);
`ifdef GMII_TX_FCS_EN
    chk({tag, "_fcs0"}, 32'(seq_q[17]), 32'h26);
    chk({tag, "_fcs1"}, 32'(seq_q[18]), 32'h39);
    chk({tag, "_fcs2"}, 32'(seq_q[19]), 32'hF4);
    chk({tag, "_fcs3"}, 32'(seq_q[20]), 32'hCB);
`endif
    chk({tag, "_done"}, 32'(n_done), 32'd1);
    chk({tag, "_underrun"}, 32'(n_und), 32'd0);
    chk({tag, "_tx_er"}, 32'(n_er), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    cif.c_srdy = 1'b1;
    cif.c_data = 8'h00;
    cif.c_code = MOP;

    // Reset state, with a MOP offered that must not be accepted.
    #2;
    chk("rst_drdy", 32'(cif.c_drdy), 32'd0);
    chk("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    chk("rst_txd", 32'(gmii_txd), 32'h00);
    chk("rst_tx_er", 32'(gmii_tx_er), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    idle(3);
    reset = 1'b0;
    #1;
    chk("idle_drdy_mop", 32'(cif.c_drdy), 32'd1);
    cif.c_code = SOP;
    #1;
    chk("idle_drdy_sop", 32'(cif.c_drdy), 32'd0);
    cif.c_srdy = 1'b0;
    idle(2);

    // Single frame.
    frame_a("single");

    // Two frames back to back.
    pay_q = {8'h10, 8'h11, 8'h12};
    mark = log_q.size();
    send_frame(EOP);
    pay_q = {8'h20, 8'h21};
    send_frame(EOP);
    idle(30);
    analyze(mark);
    chk("b2b_en_cycles", 32'(n_en), 32'(21 + 2 * FCS_EXTRA));
    chk("b2b_gap", 32'(gap), 32'd12);
    chk("b2b_done", 32'(n_done), 32'd2);
    chk("b2b_f1_last", 32'(seq_q[10]), 32'h12);
    chk("b2b_f2_pre", 32'(seq_q[11 + FCS_EXTRA]), 32'h55);
    chk("b2b_f2_first", 32'(seq_q[19 + FCS_EXTRA]), 32'h20);
    chk("b2b_f2_last", 32'(seq_q[20 + FCS_EXTRA]), 32'h21);

    // Starvation after three data bytes, rest of frame offered later.
    pay_q = {8'h40, 8'h41, 8'h42};
    build_exp();
    mark = log_q.size();
    push(8'h40, SOP);
    push(8'h41, MOP);
    push(8'h42, MOP);
    idle(5);
    push(8'h43, MOP);
    push(8'h44, EOP);
    idle(30);
    analyze(mark);
    chk("und_en_cycles", 32'(n_en), 32'd11);
    chk_seq("und_bytes", 0);
    chk("und_pulses", 32'(n_und), 32'd1);
    chk("und_position", 32'(und_idx), 32'(last_en + 1));
    chk("und_done", 32'(n_done), 32'd1);

    // Stray MOPs in IDLE, then a frame ending in BAD_EOP.
    mark = log_q.size();
    push(8'h77, MOP);
    push(8'h78, MOP);
    pay_q = {8'h50, 8'h51, 8'hAA};
    build_exp();
    send_frame(BAD);
    idle(30);
    analyze(mark);
    chk("bad_en_cycles", 32'(n_en), 32'd11);
    chk_seq("bad_bytes", 0);
    chk("bad_tx_er_count", 32'(n_er), 32'd1);
    chk("bad_tx_er_pos", 32'(er_idx), 32'(last_en));
    chk("bad_done", 32'(n_done), 32'd1);

    // Reset in the middle of DATA.
    push(8'h60, SOP);
    push(8'h61, MOP);
    push(8'h62, MOP);
    chk("mid_tx_en_before", 32'(gmii_tx_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_tx_en_async", 32'(gmii_tx_en), 32'd0);
    chk("mid_txd_async", 32'(gmii_txd), 32'h00);
    chk("mid_drdy", 32'(cif.c_drdy), 32'd0);
    mark = log_q.size();
    idle(3);
    analyze(mark);
    chk("mid_underrun", 32'(n_und), 32'd0);
    chk("mid_done", 32'(n_done), 32'd0);
    reset = 1'b0;
    idle(2);
    frame_a("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gmii_tx_engine.md
GMII_TX_ENGINE -- requirements
Module: gmii_tx_engine

Interface
REQ-001 Parameter IFG_LEN, default 12: minimum idle cycles (tx_en low) after each frame, range 1..255.
REQ-002 Parameter PRE_LEN, default 7: number of 0x55 preamble bytes before SFD, range 1..15.
REQ-003 clk  input  1  core clock; all logic on the rising edge.
REQ-004 reset  input  1  reset; asynchronous, active-high.
REQ-005 c_srdy  input  1  upstream byte valid.
REQ-006 c_drdy  output  1  byte accepted this cycle when c_srdy & c_drdy.
REQ-007 c_data  input  8  frame byte.
REQ-008 c_code  input  2  byte tag: 00 MOP, 01 SOP, 10 EOP, 11 BAD_EOP.
REQ-009 gmii_tx_en  output  1  GMII transmit enable, registered.
REQ-010 gmii_txd  output  8  GMII transmit data, registered.
REQ-011 gmii_tx_er  output  1  GMII transmit error, registered.
REQ-012 underrun  output  1  one-cycle pulse: frame truncated by source starvation.
REQ-013 frame_done  output  1  one-cycle pulse on the first IFG cycle of each frame, whether good, bad or truncated.

Function
REQ-014 FSM states: IDLE, PRE, DATA, FCS, DROP, IFG.
REQ-015 IDLE: c_drdy=1 unless c_srdy & c_code==SOP; non-SOP bytes are consumed and discarded; SOP -> PRE without consuming it.
REQ-016 PRE: c_drdy=0; PRE_LEN cycles of txd=0x55 then one cycle of 0xD5, tx_en=1; first 0x55 appears the cycle after SOP is seen in IDLE.
REQ-017 The SOP byte is transferred in the SFD cycle and appears on gmii_txd the following cycle; state -> DATA.
REQ-018 DATA: c_drdy=1; each transferred byte appears on gmii_txd, tx_en=1, one cycle later (latency 1).
REQ-019 DATA with c_srdy=0: next cycle tx_en=0, txd=0, underrun pulses; state -> DROP.
REQ-020 DROP: c_drdy=1, bytes discarded until an EOP or BAD_EOP transfer, then -> IFG.
REQ-021 DATA EOP transfer: byte sent, then -> FCS (or IFG per REQ-030).
REQ-022 DATA BAD_EOP transfer: byte sent with tx_er=1 in the same cycle; FCS is skipped; -> IFG.
REQ-023 SOP received in DATA is treated as MOP.
REQ-024 IFG: c_drdy=0, tx_en=0, txd=0, tx_er=0 for IFG_LEN cycles, then -> IDLE.
REQ-025 Back-to-back frames: the first preamble byte of the next frame is never earlier than IFG_LEN cycles after the last tx_en=1 cycle.
REQ-026 tx_er=0 in every cycle other than REQ-022.

Reset
REQ-027 While reset is high: state IDLE, counters 0, gmii_tx_en=0, gmii_txd=0x00, gmii_tx_er=0, underrun=0, frame_done=0, c_drdy=0.
REQ-028 Reset mid-frame truncates the frame immediately (tx_en drops asynchronously) with no underrun or frame_done pulse.
REQ-029 First cycle after reset release: state IDLE, c_drdy per REQ-015.

Configuration
REQ-030 Macro GMII_TX_FCS_EN defined: FCS state appends 4 bytes of IEEE 802.3 CRC-32 over SFD-excluded frame bytes (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement), LSB byte first, tx_en=1; CRC reinitialised at SOP; then -> IFG.
REQ-031 Macro GMII_TX_FCS_EN undefined: no CRC logic is present, the FCS state is unreachable, and EOP goes directly to IFG (frame bytes carry their own FCS).

Verification
REQ-032 Single frame SOP 0x31, MOP 0x32..0x38, EOP 0x39 with FCS_EN -> 7x0x55, 0xD5, 0x31..0x39, 0x26 0x39 0xF4 0xCB, tx_en high 21 cycles, frame_done once.
REQ-033 Same frame without FCS_EN -> tx_en high 17 cycles, last byte 0x39, then 12 idle cycles.
REQ-034 Two frames offered back to back, IFG_LEN=12 -> exactly 12 tx_en=0 cycles between frames.
REQ-035 c_srdy dropped after 3 data bytes, remaining bytes up to EOP offered later -> tx_en falls, underrun pulses once, remaining bytes consumed and not sent, frame_done once.
REQ-036 Frame ending in BAD_EOP 0xAA -> 0xAA sent with tx_er=1, no FCS bytes; MOP bytes offered in IDLE -> consumed and never transmitted.
REQ-037 Reset asserted mid-DATA -> tx_en=0 without waiting for a clock edge; after release the next SOP produces a complete correct frame.
